// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and encodings for the cache-to-memory miss sequencer.
package cache_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_RD    = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding memory request; expire fires on the cycle
// the limit-th consecutive ack-less cycle is reached.
module mem_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = enable && (count >= limit - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expire)
            count <= count + W'(1);
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Serialises cache miss traffic (write-back, then refill) onto a single-port
// req/ack main memory, with a per-transaction timeout and sticky error flag.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  cm_ReadValid,
    input  logic [ADDR_WIDTH-1:0] cm_ReadAddr,
    input  logic                  cm_WriteValid,
    input  logic [ADDR_WIDTH-1:0] cm_WriteAddr,
    input  logic [DATA_WIDTH-1:0] cm_WriteData,
    output logic                  cm_ReadReady,
    output logic [DATA_WIDTH-1:0] cm_ReadData,
    output logic                  cm_WriteDone,
    output logic                  mem_Req,
    output logic                  mem_RW,
    output logic [ADDR_WIDTH-1:0] mem_Addr,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    input  logic                  mem_Ack,
    input  logic [DATA_WIDTH-1:0] mem_ReadData,
    output logic                  Busy,
    output logic                  Err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_nxt;

    // Write address/data are captured straight into mem_Addr/mem_WriteData;
    // only the refill address must be held across the write-back.
    logic                  rd_pend, rd_pend_nxt;
    logic                  wr_pend, wr_pend_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;

    logic                  req_nxt, rw_nxt, ready_nxt, done_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;

    logic cnt_clear, cnt_enable, expire;

    assign Busy       = (state != ST_IDLE);
    assign cnt_enable = ((state == ST_WB) || (state == ST_RD)) && !mem_Ack;

    mem_timeout_counter #(
        .W(CNT_W)
    ) u_timeout (
        .clk   (CLK),
        .rst   (Reset),
        .clear (cnt_clear),
        .enable(cnt_enable),
        .limit (CNT_W'(TIMEOUT_CYCLES)),
        .expire(expire)
    );

    always_comb begin
        state_nxt   = state;
        rd_pend_nxt = rd_pend;
        wr_pend_nxt = wr_pend;
        rd_addr_nxt = rd_addr;
        req_nxt     = mem_Req;
        rw_nxt      = mem_RW;
        addr_nxt    = mem_Addr;
        wdata_nxt   = mem_WriteData;
        rdata_nxt   = cm_ReadData;
        ready_nxt   = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = Err;
        cnt_clear   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cm_WriteValid || cm_ReadValid) begin
                    rd_pend_nxt = cm_ReadValid;
                    wr_pend_nxt = cm_WriteValid;
                    rd_addr_nxt = cm_ReadAddr;
                    wdata_nxt   = cm_WriteData;
                    req_nxt     = 1'b1;
                    cnt_clear   = 1'b1;
                    if (cm_WriteValid) begin
                        state_nxt = ST_WB;
                        rw_nxt    = MEM_WRITE;
                        addr_nxt  = cm_WriteAddr;
                    end else begin
                        state_nxt = ST_RD;
                        rw_nxt    = MEM_READ;
                        addr_nxt  = cm_ReadAddr;
                    end
                end
            end

            ST_WB: begin
                if (mem_Ack) begin
                    if (rd_pend) begin
                        // Chain straight into the refill with mem_Req held high.
                        state_nxt = ST_RD;
                        rw_nxt    = MEM_READ;
                        addr_nxt  = rd_addr;
                        cnt_clear = 1'b1;
                    end else begin
                        state_nxt = ST_RESP;
                        req_nxt   = 1'b0;
                        done_nxt  = wr_pend;
                    end
                end else if (expire) begin
                    state_nxt = ST_DRAIN;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end
            end

            ST_RD: begin
                if (mem_Ack) begin
                    state_nxt = ST_RESP;
                    req_nxt   = 1'b0;
                    ready_nxt = 1'b1;
                    rdata_nxt = mem_ReadData;
                end else if (expire) begin
                    state_nxt = ST_DRAIN;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end
            end

            ST_RESP: state_nxt = ST_DRAIN;

            ST_DRAIN: begin
                // Hold off until the cache drops its request, so it is not relaunched.
                if (!cm_ReadValid && !cm_WriteValid)
                    state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            rd_addr       <= '0;
            mem_Req       <= 1'b0;
            mem_RW        <= MEM_READ;
            mem_Addr      <= '0;
            mem_WriteData <= '0;
            cm_ReadData   <= '0;
            cm_ReadReady  <= 1'b0;
            cm_WriteDone  <= 1'b0;
            Err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            rd_pend       <= rd_pend_nxt;
            wr_pend       <= wr_pend_nxt;
            rd_addr       <= rd_addr_nxt;
            mem_Req       <= req_nxt;
            mem_RW        <= rw_nxt;
            mem_Addr      <= addr_nxt;
            mem_WriteData <= wdata_nxt;
            cm_ReadData   <= rdata_nxt;
            cm_ReadReady  <= ready_nxt;
            cm_WriteDone  <= done_nxt;
            Err           <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: refill, write-back chaining, drain, timeout, async reset.
module tb_cache_mem_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cm_ReadValid = 1'b0;
    logic [31:0] cm_ReadAddr = '0;
    logic        cm_WriteValid = 1'b0;
    logic [31:0] cm_WriteAddr = '0;
    logic [31:0] cm_WriteData = '0;
    logic        cm_ReadReady;
    logic [31:0] cm_ReadData;
    logic        cm_WriteDone;
    logic        mem_Req;
    logic        mem_RW;
    logic [31:0] mem_Addr;
    logic [31:0] mem_WriteData;
    logic        mem_Ack = 1'b0;
    logic [31:0] mem_ReadData = '0;
    logic        Busy;
    logic        Err;

    int vecs = 0;
    int errs = 0;
    int rr_cnt = 0;
    int wd_cnt = 0;

    cache_mem_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .cm_ReadValid(cm_ReadValid), .cm_ReadAddr(cm_ReadAddr),
        .cm_WriteValid(cm_WriteValid), .cm_WriteAddr(cm_WriteAddr), .cm_WriteData(cm_WriteData),
        .cm_ReadReady(cm_ReadReady), .cm_ReadData(cm_ReadData), .cm_WriteDone(cm_WriteDone),
        .mem_Req(mem_Req), .mem_RW(mem_RW), .mem_Addr(mem_Addr), .mem_WriteData(mem_WriteData),
        .mem_Ack(mem_Ack), .mem_ReadData(mem_ReadData),
        .Busy(Busy), .Err(Err)
    );

    always #5 CLK = ~CLK;

    // Pulses last one cycle, so counting high cycles counts pulses.
    always @(negedge CLK) begin
        if (cm_ReadReady) rr_cnt++;
        if (cm_WriteDone) wd_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        vecs++; if ({mem_Req, mem_RW, cm_ReadReady, cm_WriteDone, Busy, Err} !== 6'b0) begin errs++; $display("FAIL reset_ctrl: got %b want 000000", {mem_Req, mem_RW, cm_ReadReady, cm_WriteDone, Busy, Err}); end
        vecs++; if ({mem_Addr, mem_WriteData, cm_ReadData} !== 96'h0) begin errs++; $display("FAIL reset_data: got %h want 0", {mem_Addr, mem_WriteData, cm_ReadData}); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_refill();
        rr_cnt = 0; wd_cnt = 0;
        cm_ReadValid = 1'b1; cm_ReadAddr = 32'h0000_1040;
        tick();
        vecs++; if ({mem_Req, mem_RW, Busy} !== 3'b101) begin errs++; $display("FAIL refill_req: got %b want 101", {mem_Req, mem_RW, Busy}); end
        vecs++; if (mem_Addr !== 32'h0000_1040) begin errs++; $display("FAIL refill_addr: got %h want 00001040", mem_Addr); end
        tick(); tick();
        mem_Ack = 1'b1; mem_ReadData = 32'hDEAD_BEEF;
        tick();
        mem_Ack = 1'b0; mem_ReadData = '0;
        vecs++; if ({cm_ReadReady, mem_Req} !== 2'b10) begin errs++; $display("FAIL refill_ready: got %b want 10", {cm_ReadReady, mem_Req}); end
        vecs++; if (cm_ReadData !== 32'hDEAD_BEEF) begin errs++; $display("FAIL refill_data: got %h want deadbeef", cm_ReadData); end
        tick();
        vecs++; if (cm_ReadReady !== 1'b0) begin errs++; $display("FAIL refill_pulse_len: got %b want 0", cm_ReadReady); end
        cm_ReadValid = 1'b0;
        tick();
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL refill_idle: got %b want 0", Busy); end
        vecs++; if ({rr_cnt, wd_cnt} !== {32'd1, 32'd0}) begin errs++; $display("FAIL refill_pulses: got rr=%0d wd=%0d want rr=1 wd=0", rr_cnt, wd_cnt); end
    endtask

    task automatic test_wb_refill();
        rr_cnt = 0; wd_cnt = 0;
        cm_ReadValid = 1'b1; cm_ReadAddr = 32'h0000_3000;
        cm_WriteValid = 1'b1; cm_WriteAddr = 32'h0000_2000; cm_WriteData = 32'h1234_5678;
        tick();
        vecs++; if ({mem_Req, mem_RW} !== 2'b11) begin errs++; $display("FAIL wb_req: got %b want 11", {mem_Req, mem_RW}); end
        vecs++; if ({mem_Addr, mem_WriteData} !== {32'h0000_2000, 32'h1234_5678}) begin errs++; $display("FAIL wb_addr_data: got %h %h want 00002000 12345678", mem_Addr, mem_WriteData); end
        mem_Ack = 1'b1;
        tick();
        mem_Ack = 1'b0;
        vecs++; if ({mem_Req, mem_RW} !== 2'b10) begin errs++; $display("FAIL wb_chain_req: got %b want 10", {mem_Req, mem_RW}); end
        vecs++; if (mem_Addr !== 32'h0000_3000) begin errs++; $display("FAIL wb_chain_addr: got %h want 00003000", mem_Addr); end
        mem_Ack = 1'b1; mem_ReadData = 32'hCAFE_F00D;
        tick();
        mem_Ack = 1'b0; mem_ReadData = '0;
        vecs++; if ({cm_ReadReady, cm_ReadData} !== {1'b1, 32'hCAFE_F00D}) begin errs++; $display("FAIL wb_refill_data: got %b %h want 1 cafef00d", cm_ReadReady, cm_ReadData); end
        tick();
        cm_ReadValid = 1'b0; cm_WriteValid = 1'b0;
        tick();
        vecs++; if ({rr_cnt, wd_cnt} !== {32'd1, 32'd0}) begin errs++; $display("FAIL wb_refill_pulses: got rr=%0d wd=%0d want rr=1 wd=0", rr_cnt, wd_cnt); end
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL wb_refill_idle: got %b want 0", Busy); end
    endtask

    task automatic test_write_only();
        rr_cnt = 0; wd_cnt = 0;
        cm_WriteValid = 1'b1; cm_WriteAddr = 32'h0000_4000; cm_WriteData = 32'hA5A5_5A5A;
        tick();
        mem_Ack = 1'b1;
        tick();
        mem_Ack = 1'b0;
        vecs++; if ({cm_WriteDone, cm_ReadReady, mem_Req} !== 3'b100) begin errs++; $display("FAIL wr_done: got %b want 100", {cm_WriteDone, cm_ReadReady, mem_Req}); end
        tick();
        vecs++; if ({cm_WriteDone, Busy} !== 2'b01) begin errs++; $display("FAIL wr_drain: got %b want 01", {cm_WriteDone, Busy}); end
        cm_WriteValid = 1'b0;
        tick();
        vecs++; if (Busy !== 1'b0) begin errs++; $display("FAIL wr_idle: got %b want 0", Busy); end
        vecs++; if ({rr_cnt, wd_cnt} !== {32'd0, 32'd1}) begin errs++; $display("FAIL wr_pulses: got rr=%0d wd=%0d want rr=0 wd=1", rr_cnt, wd_cnt); end
    endtask

    task automatic test_drain_hold();
        int req_seen;
        req_seen = 0;
        cm_ReadValid = 1'b1; cm_ReadAddr = 32'h0000_5000;
        tick();
        mem_Ack = 1'b1; mem_ReadData = 32'h0BAD_C0DE;
        tick();
        mem_Ack = 1'b0; mem_ReadData = '0;
        vecs++; if (cm_ReadReady !== 1'b1) begin errs++; $display("FAIL drain_ready: got %b want 1", cm_ReadReady); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_Req) req_seen++;
        end
        vecs++; if ({req_seen, Busy} !== {32'd0, 1'b1}) begin errs++; $display("FAIL drain_no_relaunch: got req=%0d busy=%b want 0 1", req_seen, Busy); end
        cm_ReadValid = 1'b0;
        tick();
        vecs++; if ({Busy, cm_ReadData} !== {1'b0, 32'h0BAD_C0DE}) begin errs++; $display("FAIL drain_release: got %b %h want 0 0badc0de", Busy, cm_ReadData); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        rr_cnt = 0;
        req_cycles = 0;
        cm_ReadValid = 1'b1; cm_ReadAddr = 32'h0000_6000;
        tick();
        for (int i = 0; i < 12 && mem_Req; i++) begin
            req_cycles++;
            tick();
        end
        vecs++; if (req_cycles !== 8) begin errs++; $display("FAIL timeout_len: got %0d want 8", req_cycles); end
        vecs++; if ({Err, cm_ReadReady, Busy} !== 3'b101) begin errs++; $display("FAIL timeout_err: got %b want 101", {Err, cm_ReadReady, Busy}); end
        cm_ReadValid = 1'b0;
        tick();
        vecs++; if ({Err, Busy} !== 2'b10) begin errs++; $display("FAIL timeout_sticky: got %b want 10", {Err, Busy}); end
        cm_ReadValid = 1'b1; cm_ReadAddr = 32'h0000_7000;
        tick();
        vecs++; if ({mem_Req, mem_Addr} !== {1'b1, 32'h0000_7000}) begin errs++; $display("FAIL timeout_next_req: got %b %h want 1 00007000", mem_Req, mem_Addr); end
        mem_Ack = 1'b1; mem_ReadData = 32'h1111_2222;
        tick();
        mem_Ack = 1'b0; mem_ReadData = '0;
        cm_ReadValid = 1'b0;
        vecs++; if ({cm_ReadReady, Err, cm_ReadData} !== {2'b11, 32'h1111_2222}) begin errs++; $display("FAIL timeout_next_data: got %b%b %h want 11 11112222", cm_ReadReady, Err, cm_ReadData); end
        tick(); tick();
        vecs++; if (rr_cnt !== 1) begin errs++; $display("FAIL timeout_pulses: got %0d want 1", rr_cnt); end
    endtask

    task automatic test_async_reset();
        cm_WriteValid = 1'b1; cm_WriteAddr = 32'h0000_8000; cm_WriteData = 32'h5555_AAAA;
        tick();
        vecs++; if ({mem_Req, mem_RW, Busy} !== 3'b111) begin errs++; $display("FAIL areset_in_wb: got %b want 111", {mem_Req, mem_RW, Busy}); end
        #2 Reset = 1'b1;
        #1;
        vecs++; if ({mem_Req, Busy, Err} !== 3'b000) begin errs++; $display("FAIL areset_immediate: got %b want 000", {mem_Req, Busy, Err}); end
        cm_WriteValid = 1'b0;
        rr_cnt = 0; wd_cnt = 0;
        tick();
        Reset = 1'b0;
        tick(); tick(); tick();
        vecs++; if ({rr_cnt, wd_cnt, 1'b0, mem_Req, Busy} !== {64'd0, 3'b000}) begin errs++; $display("FAIL areset_after: got rr=%0d wd=%0d req=%b busy=%b want 0 0 0 0", rr_cnt, wd_cnt, mem_Req, Busy); end
    endtask

    initial begin
        test_reset();
        test_refill();
        test_wb_refill();
        test_write_only();
        test_drain_hold();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Sequences cache miss traffic to main memory.
- Sits between the set-associative cache's memory-side (cm_) interface and a single-port, variable-latency main memory using a req/ack handshake.
- Serialises a dirty-line write-back ahead of the refill read, returns refill data with a one-cycle ready pulse, and guards every memory transaction with a timeout.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data word width on both sides.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_Ack before abort; must be ≥1.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- cm_ReadValid  in  1  cache requests refill read.
- cm_ReadAddr  in  ADDR_WIDTH  refill address.
- cm_WriteValid  in  1  cache requests dirty write-back.
- cm_WriteAddr  in  ADDR_WIDTH  write-back address.
- cm_WriteData  in  DATA_WIDTH  write-back data.
- cm_ReadReady  out  1  one-cycle pulse: refill data valid.
- cm_ReadData  out  DATA_WIDTH  refill data, registered.
- cm_WriteDone  out  1  one-cycle pulse: standalone write-back complete.
- mem_Req  out  1  memory request.
- mem_RW  out  1  0 read, 1 write.
- mem_Addr  out  ADDR_WIDTH  memory address.
- mem_WriteData  out  DATA_WIDTH  memory write data.
- mem_Ack  in  1  memory completes the current request; single-cycle.
- mem_ReadData  in  DATA_WIDTH  valid when mem_Ack=1 and mem_RW=0.
- Busy  out  1  state != IDLE.
- Err  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, Err 0. Reset is asynchronous, so it takes effect mid-transaction: mem_Req drops immediately and no completion pulse is issued.
- States: IDLE, WB, RD, RESP, DRAIN.
- IDLE request capture:
  - Samples cm_WriteValid and cm_ReadValid each cycle.
  - Either one high latches cm_ReadAddr, cm_WriteAddr, cm_WriteData and both valid bits into internal registers.
  - Inputs are not re-sampled until the next return to IDLE.
- IDLE transitions:
  - WriteValid=1 → WB, with mem_Req=1, mem_RW=1, mem_Addr=write address, mem_WriteData=latched data. This holds whether or not ReadValid is high: write-back always precedes refill.
  - WriteValid=0 and ReadValid=1 → RD, with mem_Req=1, mem_RW=0, mem_Addr=read address.
- WB, on mem_Ack:
  - Latched read pending → RD: mem_Req stays 1, mem_RW=0, mem_Addr=read address, so there is no idle cycle between the two transactions.
  - No read pending → RESP, with cm_WriteDone=1 for one cycle.
- RD, on mem_Ack:
  - Registers mem_ReadData into cm_ReadData.
  - cm_ReadReady=1 for exactly one cycle, the cycle after the ack.
  - mem_Req=0 → RESP.
- RESP (one cycle, pulse cycle) → DRAIN.
- DRAIN:
  - Waits until cm_ReadValid=0 and cm_WriteValid=0, then → IDLE.
  - This prevents relaunching a request the cache has not yet dropped.
  - cm_ReadData holds its value until the next refill.
- mem_Req/ack protocol:
  - mem_Req, mem_RW, mem_Addr and mem_WriteData are registered and stable while mem_Req=1.
  - mem_Ack with mem_Req=0 is ignored.
  - mem_Ack in the same cycle the request is issued is legal: ack is sampled from the first cycle mem_Req=1.
- Timeout:
  - Counter clears on entry to WB or RD and increments each cycle without mem_Ack.
  - On reaching TIMEOUT_CYCLES: Err=1 (sticky until Reset), mem_Req=0, no ready/done pulse, state → DRAIN.
- Minimum latency: refill with mem_Ack in its first request cycle gives cm_ReadReady 2 cycles after cm_ReadValid is first seen in IDLE. Write-back+refill adds the write-back ack latency.
- Width rule: cm_ReadData is taken verbatim from mem_ReadData; no address arithmetic is performed.

Decomposition:
- Shared package/include (config.v):
  - State encoding localparams: ST_IDLE=0, ST_WB=1, ST_RD=2, ST_RESP=3, ST_DRAIN=4, 3-bit.
  - MEM_READ=0, MEM_WRITE=1.
- Sub-module: mem_timeout_counter (clear, enable, limit → expire), width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Clean refill:
  - Stimulus: Reset, then cm_ReadValid=1, cm_ReadAddr=0x0000_1040; memory acks 3 cycles after mem_Req rises with 0xDEAD_BEEF.
  - Response: mem_RW=0, mem_Addr=0x1040, one cm_ReadReady pulse with cm_ReadData=0xDEAD_BEEF, cm_WriteDone never pulses.
- Write-back then refill:
  - Stimulus: ReadValid and WriteValid both 1, WriteAddr=0x2000, WriteData=0x1234_5678, ReadAddr=0x3000.
  - Response: write with those values first; mem_Req stays high into the read at 0x3000 with no gap; single cm_ReadReady; no cm_WriteDone.
- Standalone write:
  - Stimulus: WriteValid only, acked in the first request cycle.
  - Response: one cm_WriteDone pulse, cm_ReadReady stays 0, Busy returns to 0 once WriteValid drops.
- Drain hold:
  - Stimulus: cm_ReadValid held high 5 cycles after the ready pulse.
  - Response: no second mem_Req; return to IDLE one cycle after it drops.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, no mem_Ack.
  - Response: mem_Req falls after 8 cycles, Err=1 and sticky, no ready pulse; the next request is still serviced.
- Async reset mid-WB:
  - Stimulus: assert Reset between clock edges while in WB.
  - Response: mem_Req=0, Busy=0 and Err=0 before the next edge; no pulses afterwards.
